// File: rtl/or_matrix_pkg.sv
// Shared types for the OR-mask matrix.
// Holds the per-channel output mode encoding.
package or_matrix_pkg;

    typedef enum logic [1:0] {
        MODE_LEVEL  = 2'b00,
        MODE_STICKY = 2'b01,
        MODE_RISE   = 2'b10,
        MODE_OFF    = 2'b11
    } mode_e;

endpackage

// File: rtl/or_matrix_chan.sv
// One OR-mask channel: mask/mode registers, hit reduce, mode output logic.
// Ports: clk, rst, i_in_q (registered input), i_wr/i_wr_mask/i_wr_mode
// (config write), i_sticky_clr, o_out (registered channel output).
module or_matrix_chan
    import or_matrix_pkg::*;
#(
    parameter int              IN_W     = 8,
    parameter logic [IN_W-1:0] MASK_RST = '0
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [IN_W-1:0] i_in_q,
    input  logic            i_wr,
    input  logic [IN_W-1:0] i_wr_mask,
    input  mode_e           i_wr_mode,
    input  logic            i_sticky_clr,
    output logic            o_out
);

    logic [IN_W-1:0] r_mask;
    mode_e           r_mode;
    logic            r_out;
    logic            r_hit_q;
    logic            w_hit;
    logic            w_next;

    assign w_hit = |(i_in_q & r_mask);

    always_comb begin
        w_next = 1'b0;
        unique case (r_mode)
            MODE_LEVEL:  w_next = w_hit;
            MODE_STICKY: w_next = (r_out | w_hit) & ~i_sticky_clr;
            MODE_RISE:   w_next = w_hit & ~r_hit_q;
            MODE_OFF:    w_next = 1'b0;
            default:     w_next = 1'b0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_mask  <= MASK_RST;
            r_mode  <= MODE_LEVEL;
            r_out   <= 1'b0;
            r_hit_q <= 1'b0;
        end else begin
            r_out   <= w_next;
            r_hit_q <= w_hit;
            if (i_wr) begin
                r_mask <= i_wr_mask;
                r_mode <= i_wr_mode;
                // A mode switch starts the channel from a clean slate.
                if (i_wr_mode != r_mode) begin
                    r_out   <= 1'b0;
                    r_hit_q <= 1'b0;
                end
            end
        end
    end

    assign o_out = r_out;

endmodule

// File: rtl/or_mask_matrix.sv
// OR-mask matrix top: input register, config handshake, address decode.
// Ports: clk, rst, in_data, cfg_valid/cfg_ready/cfg_addr/cfg_mask/cfg_mode,
// cfg_err (bad-address pulse), sticky_clr, out_data (per-channel outputs).
module or_mask_matrix
    import or_matrix_pkg::*;
#(
    parameter int                      IN_W     = 8,
    parameter int                      N_OUT    = 8,
    parameter logic [N_OUT*IN_W-1:0]   MASK_RST = '0,
    localparam int                     ADDR_W   = (N_OUT > 1) ? $clog2(N_OUT) : 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [IN_W-1:0]   in_data,
    input  logic              cfg_valid,
    output logic              cfg_ready,
    input  logic [ADDR_W-1:0] cfg_addr,
    input  logic [IN_W-1:0]   cfg_mask,
    input  logic [1:0]        cfg_mode,
    output logic              cfg_err,
    input  logic              sticky_clr,
    output logic [N_OUT-1:0]  out_data
);

    logic [IN_W-1:0] r_in_q;
    logic            r_cfg_ready;
    logic            r_cfg_err;
    logic            w_accept;
    logic            w_addr_ok;
    logic [31:0]     w_addr32;

    assign w_accept  = cfg_valid & r_cfg_ready;
    assign w_addr32  = {{(32-ADDR_W){1'b0}}, cfg_addr};
    assign w_addr_ok = w_addr32 < 32'(N_OUT);

    // Ready drops for the single commit cycle after each accept.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_in_q      <= '0;
            r_cfg_ready <= 1'b1;
            r_cfg_err   <= 1'b0;
        end else begin
            r_in_q      <= in_data;
            r_cfg_ready <= ~w_accept;
            r_cfg_err   <= w_accept & ~w_addr_ok;
        end
    end

    assign cfg_ready = r_cfg_ready;
    assign cfg_err   = r_cfg_err;

    for (genvar k = 0; k < N_OUT; k++) begin : g_chan
        logic w_wr;
        assign w_wr = w_accept & w_addr_ok & (cfg_addr == ADDR_W'(k));

        or_matrix_chan #(
            .IN_W     (IN_W),
            .MASK_RST (MASK_RST[k*IN_W +: IN_W])
        ) u_chan (
            .clk          (clk),
            .rst          (rst),
            .i_in_q       (r_in_q),
            .i_wr         (w_wr),
            .i_wr_mask    (cfg_mask),
            .i_wr_mode    (mode_e'(cfg_mode)),
            .i_sticky_clr (sticky_clr),
            .o_out        (out_data[k])
        );
    end

endmodule

// File: tb/tb_or_mask_matrix.sv
// Directed bench for or_mask_matrix: default 8-channel instance plus a
// 6-channel instance with a non-zero reset mask image.
module tb_or_mask_matrix;

    logic       clk = 1'b0;
    always #5 clk = ~clk;

    // Default instance (IN_W=8, N_OUT=8, zero masks)
    logic       rst, cfg_valid, cfg_ready, cfg_err, sticky_clr;
    logic [7:0] in_data, cfg_mask, out_data;
    logic [2:0] cfg_addr;
    logic [1:0] cfg_mode;

    // Six-channel instance, channel k reset mask = 1 << k
    logic       rst6, cfg_valid6, cfg_ready6, cfg_err6, sticky_clr6;
    logic [7:0] in6, cfg_mask6;
    logic [5:0] out6;
    logic [2:0] cfg_addr6;
    logic [1:0] cfg_mode6;

    or_mask_matrix u_dut (
        .clk        (clk),
        .rst        (rst),
        .in_data    (in_data),
        .cfg_valid  (cfg_valid),
        .cfg_ready  (cfg_ready),
        .cfg_addr   (cfg_addr),
        .cfg_mask   (cfg_mask),
        .cfg_mode   (cfg_mode),
        .cfg_err    (cfg_err),
        .sticky_clr (sticky_clr),
        .out_data   (out_data)
    );

    or_mask_matrix #(
        .IN_W     (8),
        .N_OUT    (6),
        .MASK_RST (48'h20_10_08_04_02_01)
    ) u_dut6 (
        .clk        (clk),
        .rst        (rst6),
        .in_data    (in6),
        .cfg_valid  (cfg_valid6),
        .cfg_ready  (cfg_ready6),
        .cfg_addr   (cfg_addr6),
        .cfg_mask   (cfg_mask6),
        .cfg_mode   (cfg_mode6),
        .cfg_err    (cfg_err6),
        .sticky_clr (sticky_clr6),
        .out_data   (out6)
    );

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t",
                     name, act, exp, $time);
        end
    endtask

    // Enter and leave on a falling edge.
    task automatic wr8(input logic [2:0] a, input logic [7:0] m,
                       input logic [1:0] md, input bit junk);
        cfg_valid = 1'b1;
        cfg_addr  = a;
        cfg_mask  = m;
        cfg_mode  = md;
        chk("rdy_idle", 32'(cfg_ready), 32'd1);
        @(negedge clk);
        chk("rdy_commit", 32'(cfg_ready), 32'd0);
        chk("err_quiet", 32'(cfg_err), 32'd0);
        if (junk) begin
            // Held request with different data must be ignored.
            cfg_mask = 8'hFF;
            cfg_mode = 2'b01;
        end else begin
            cfg_valid = 1'b0;
        end
        @(negedge clk);
        cfg_valid = 1'b0;
        chk("rdy_back", 32'(cfg_ready), 32'd1);
    endtask

    typedef struct {
        logic [7:0] in;
        logic       clr;
        logic [7:0] exp;
    } vec_t;

    vec_t tbl[14];

    initial begin
        // ch0 LEVEL 06, ch1 STICKY C0, ch2 RISE 0F.
        // exp[i] is checked before driving in[i]; it reflects in[i-2].
        tbl[0]  = '{8'h04, 1'b0, 8'h00};
        tbl[1]  = '{8'h01, 1'b0, 8'h00};
        tbl[2]  = '{8'h80, 1'b0, 8'h05};
        tbl[3]  = '{8'h00, 1'b0, 8'h00};
        tbl[4]  = '{8'h00, 1'b0, 8'h02};
        tbl[5]  = '{8'h01, 1'b0, 8'h02};
        tbl[6]  = '{8'h01, 1'b0, 8'h02};
        tbl[7]  = '{8'h01, 1'b0, 8'h06};
        tbl[8]  = '{8'h01, 1'b0, 8'h02};
        tbl[9]  = '{8'h01, 1'b0, 8'h02};
        tbl[10] = '{8'h40, 1'b0, 8'h02};
        tbl[11] = '{8'h00, 1'b1, 8'h02};
        tbl[12] = '{8'h00, 1'b0, 8'h00};
        tbl[13] = '{8'h00, 1'b0, 8'h00};

        rst = 1'b1; cfg_valid = 1'b0; cfg_addr = '0; cfg_mask = '0;
        cfg_mode = '0; sticky_clr = 1'b0; in_data = '0;
        rst6 = 1'b1; cfg_valid6 = 1'b0; cfg_addr6 = '0; cfg_mask6 = '0;
        cfg_mode6 = '0; sticky_clr6 = 1'b0; in6 = '0;

        repeat (2) @(negedge clk);
        rst  = 1'b0;
        rst6 = 1'b0;
        chk("rst_ready", 32'(cfg_ready), 32'd1);
        chk("rst_err", 32'(cfg_err), 32'd0);
        chk("rst_out", 32'(out_data), 32'd0);

        // Zero masks: nothing ever fires.
        in_data = 8'h01;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("zero_mask_out", 32'(out_data), 32'd0);
        end
        in_data = 8'h00;
        repeat (2) @(negedge clk);

        wr8(3'd0, 8'h06, 2'b00, 1'b1);
        wr8(3'd1, 8'hC0, 2'b01, 1'b0);
        wr8(3'd2, 8'h0F, 2'b10, 1'b0);

        for (int i = 0; i < 14; i++) begin
            chk($sformatf("vec%0d", i), 32'(out_data), 32'(tbl[i].exp));
            in_data    = tbl[i].in;
            sticky_clr = tbl[i].clr;
            @(negedge clk);
        end
        sticky_clr = 1'b0;

        // Mode change clears the channel at the accept edge.
        in_data = 8'h80;
        repeat (3) @(negedge clk);
        chk("sticky_set", 32'(out_data[1]), 32'd1);
        cfg_valid = 1'b1; cfg_addr = 3'd1; cfg_mask = 8'hC0; cfg_mode = 2'b00;
        @(negedge clk);
        cfg_valid = 1'b0;
        chk("mode_chg_clr", 32'(out_data[1]), 32'd0);
        @(negedge clk);
        chk("mode_chg_level", 32'(out_data[1]), 32'd1);
        in_data = 8'h00;
        repeat (2) @(negedge clk);
        chk("level_drop", 32'(out_data[1]), 32'd0);

        // Six-channel instance: reset masks are one-hot per channel.
        in6 = 8'h3F;
        repeat (2) @(negedge clk);
        chk("d6_rst_mask", 32'(out6), 32'h3F);
        in6 = 8'h05;
        repeat (2) @(negedge clk);
        chk("d6_pattern", 32'(out6), 32'h05);

        // Out-of-range address: accepted, no state change, one err pulse.
        cfg_valid6 = 1'b1; cfg_addr6 = 3'd7; cfg_mask6 = 8'hFF;
        cfg_mode6 = 2'b11;
        chk("d6_err_pre", 32'(cfg_err6), 32'd0);
        @(negedge clk);
        cfg_valid6 = 1'b0;
        chk("d6_bad_rdy", 32'(cfg_ready6), 32'd0);
        chk("d6_err_pulse", 32'(cfg_err6), 32'd1);
        @(negedge clk);
        chk("d6_err_end", 32'(cfg_err6), 32'd0);
        chk("d6_bad_rdy_back", 32'(cfg_ready6), 32'd1);
        in6 = 8'h3F;
        repeat (2) @(negedge clk);
        chk("d6_bad_nochg", 32'(out6), 32'h3F);

        // Zero mask on ch2 silences it.
        cfg_valid6 = 1'b1; cfg_addr6 = 3'd2; cfg_mask6 = 8'h00;
        cfg_mode6 = 2'b00;
        @(negedge clk);
        cfg_valid6 = 1'b0;
        @(negedge clk);
        chk("d6_zero_ch2", 32'(out6), 32'h3B);

        // Reset in the commit cycle restores reset masks.
        cfg_valid6 = 1'b1; cfg_addr6 = 3'd1; cfg_mask6 = 8'h00;
        cfg_mode6 = 2'b11;
        @(negedge clk);
        cfg_valid6 = 1'b0;
        chk("d6_commit_rdy", 32'(cfg_ready6), 32'd0);
        rst6 = 1'b1;
        @(negedge clk);
        rst6 = 1'b0;
        chk("d6_rst_rdy", 32'(cfg_ready6), 32'd1);
        chk("d6_rst_out", 32'(out6), 32'd0);
        repeat (2) @(negedge clk);
        chk("d6_rst_restore", 32'(out6), 32'h3F);

        // A write presented during reset is discarded.
        rst6 = 1'b1;
        cfg_valid6 = 1'b1; cfg_addr6 = 3'd0; cfg_mask6 = 8'h00;
        cfg_mode6 = 2'b11;
        @(negedge clk);
        rst6 = 1'b0;
        cfg_valid6 = 1'b0;
        chk("d6_rstwr_rdy", 32'(cfg_ready6), 32'd1);
        repeat (2) @(negedge clk);
        chk("d6_rstwr_drop", 32'(out6), 32'h3F);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end

endmodule
